// File: rtl/ps2_rx_teclado_pkg.sv
// Shared PS/2 scan-code constants and receiver FSM states.
package ps2_codigos;

   localparam logic [7:0] PS2_BREAK    = 8'hF0;
   localparam logic [7:0] PS2_EXT      = 8'hE0;
   localparam logic [7:0] TECLA_ARRIBA = 8'h75;
   localparam logic [7:0] TECLA_ABAJO  = 8'h72;
   localparam logic [7:0] TECLA_SUBE   = 8'h73;

   typedef enum logic [1:0] {
      IDLE,
      DATOS,
      PARIDAD,
      PARADA
   } estado_t;

endpackage

// File: rtl/ps2_rx_teclado_filtro.sv
// Two-flop synchroniser followed by a level filter: the output follows the
// input only after FILT consecutive identical synchronised samples.
module ps2_filtro #(
   parameter int FILT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int CW = $clog2(FILT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

   logic          s1, s2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         dout <= 1'b1;
         cnt  <= '0;
      end else begin
         s1 <= din;
         s2 <= s1;
         // Any sample agreeing with the current level restarts the run.
         if (s2 == dout) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            dout <= s2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_rx_teclado.sv
// PS/2 keyboard receiver: frames are sampled on filtered clock falls, break
// sequences are swallowed and each make code yields one got_data strobe.
module ps2_rx_teclado #(
   parameter int FILT = 8,
   parameter int TOUT = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] Cambio,
   output logic       got_data,
   output logic       extendido,
   output logic       error
);

   import ps2_codigos::*;

   localparam int WW = $clog2(TOUT);
   localparam logic [WW-1:0] WD_MAX = WW'(TOUT - 1);

   logic          clk_f, dat_f;
   logic          clk_prev, caida;
   estado_t       estado;
   logic [2:0]    nbit;
   logic [7:0]    sh;
   logic          par;
   logic [WW-1:0] wd;
   logic          f_break, f_ext;

   ps2_filtro #(.FILT(FILT)) u_filt_clk (
      .clk  (clk),
      .rst  (rst),
      .din  (ps2_clk),
      .dout (clk_f)
   );

   ps2_filtro #(.FILT(FILT)) u_filt_dat (
      .clk  (clk),
      .rst  (rst),
      .din  (ps2_data),
      .dout (dat_f)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_prev <= 1'b1;
         caida    <= 1'b0;
      end else begin
         clk_prev <= clk_f;
         caida    <= clk_prev & ~clk_f;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado    <= IDLE;
         nbit      <= '0;
         sh        <= '0;
         par       <= 1'b0;
         wd        <= '0;
         f_break   <= 1'b0;
         f_ext     <= 1'b0;
         Cambio    <= '0;
         got_data  <= 1'b0;
         extendido <= 1'b0;
         error     <= 1'b0;
      end else begin
         got_data <= 1'b0;
         error    <= 1'b0;
         if (caida) begin
            wd <= '0;
            case (estado)
               IDLE: begin
                  if (!dat_f) begin
                     estado <= DATOS;
                     nbit   <= '0;
                  end
               end
               DATOS: begin
                  sh <= {dat_f, sh[7:1]};
                  if (nbit == 3'd7) estado <= PARIDAD;
                  else              nbit   <= nbit + 1'b1;
               end
               PARIDAD: begin
                  par    <= dat_f;
                  estado <= PARADA;
               end
               PARADA: begin
                  estado <= IDLE;
                  if (dat_f && (^{sh, par})) begin
                     if (sh == PS2_EXT) begin
                        f_ext <= 1'b1;
                     end else if (sh == PS2_BREAK) begin
                        f_break <= 1'b1;
                     end else if (f_break) begin
                        f_break <= 1'b0;
                        f_ext   <= 1'b0;
                     end else begin
                        Cambio    <= sh;
                        extendido <= f_ext;
                        got_data  <= 1'b1;
                        f_ext     <= 1'b0;
                     end
                  end else begin
                     error <= 1'b1;
                  end
               end
               default: estado <= IDLE;
            endcase
         end else if (estado != IDLE) begin
            // A stalled frame also drops any pending prefix state.
            if (wd == WD_MAX) begin
               error   <= 1'b1;
               estado  <= IDLE;
               wd      <= '0;
               f_break <= 1'b0;
               f_ext   <= 1'b0;
            end else begin
               wd <= wd + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_rx_teclado.sv
// Scoreboard bench for ps2_rx_teclado: expected strobe/error events are queued
// by the stimulus and consumed by a monitor whenever the DUT reports one.
module tb_ps2_rx_teclado;

   localparam int FILT = 8;
   localparam int TOUT = 300;
   localparam int H    = 20;

   typedef struct {
      bit         err;
      logic [7:0] code;
      logic       ext;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] Cambio;
   logic       got_data, extendido, error;

   ev_t  q[$];
   ev_t  e;
   int   n_cmp = 0;
   int   n_mis = 0;
   logic gd_prev = 1'b0;

   ps2_rx_teclado #(.FILT(FILT), .TOUT(TOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .Cambio    (Cambio),
      .got_data  (got_data),
      .extendido (extendido),
      .error     (error)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded time budget");
      $fatal(1);
   end

   // Monitor: every got_data or error pulse must match the head of the queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (got_data || error) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_mis++;
               $display("FAIL unexpected_event: got_data=%0b error=%0b Cambio=%h, expected no event",
                        got_data, error, Cambio);
            end else begin
               e = q.pop_front();
               if (got_data != !e.err || error != e.err ||
                   (!e.err && (Cambio != e.code || extendido != e.ext))) begin
                  n_mis++;
                  $display("FAIL event: got got_data=%0b error=%0b Cambio=%h ext=%0b, expected err=%0b Cambio=%h ext=%0b",
                           got_data, error, Cambio, extendido, e.err, e.code, e.ext);
               end
            end
         end
         if (got_data && gd_prev) begin
            n_cmp++;
            n_mis++;
            $display("FAIL strobe_width: got_data high 2 cycles, expected 1");
         end
      end
      gd_prev = got_data;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_code(input logic [7:0] c, input logic x);
      ev_t t;
      t.err = 1'b0; t.code = c; t.ext = x;
      q.push_back(t);
   endtask

   task automatic push_err();
      ev_t t;
      t.err = 1'b1; t.code = 8'h00; t.ext = 1'b0;
      q.push_back(t);
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      ps2_data = b;
      if (glitch) begin
         wait_cyc(5);
         ps2_clk = 1'b0;
         wait_cyc(3);
         ps2_clk = 1'b1;
         wait_cyc(H - 8);
      end else begin
         wait_cyc(H);
      end
      ps2_clk = 1'b0;
      wait_cyc(H);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic p, input logic s, input bit glitch);
      send_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
      send_bit(p, glitch);
      send_bit(s, glitch);
      ps2_data = 1'b1;
      wait_cyc(2 * H);
   endtask

   task automatic send_partial(input logic [7:0] b);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(b[i], 1'b0);
      ps2_data = 1'b1;
   endtask

   task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_Cambio"},    Cambio,           8'h00);
      check_val({tag, "_got_data"},  {7'd0, got_data}, 8'h00);
      check_val({tag, "_extendido"}, {7'd0, extendido}, 8'h00);
      check_val({tag, "_error"},     {7'd0, error},    8'h00);
   endtask

   initial begin
      wait_cyc(5);
      check_reset_vals("reset");
      rst = 1'b0;
      wait_cyc(20);

      // Plain make code
      push_code(8'h73, 1'b0);
      send_frame(8'h73, 1'b0, 1'b1, 1'b0);
      check_val("hold_after_73", Cambio, 8'h73);

      // Make / break / code: a single strobe
      push_code(8'h72, 1'b0);
      send_frame(8'h72, 1'b1, 1'b1, 1'b0);
      send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
      send_frame(8'h72, 1'b1, 1'b1, 1'b0);

      // Parity error keeps the previous code, then normal reception
      push_err();
      send_frame(8'h73, 1'b1, 1'b1, 1'b0);
      check_val("hold_after_parity_err", Cambio, 8'h72);
      push_err();
      send_frame(8'h73, 1'b0, 1'b0, 1'b0);
      check_val("hold_after_stop_err", Cambio, 8'h72);
      push_code(8'h72, 1'b0);
      send_frame(8'h72, 1'b1, 1'b1, 1'b0);

      // Extended prefix, then a plain code clears it
      push_code(8'h75, 1'b1);
      send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h75, 1'b0, 1'b1, 1'b0);
      push_code(8'h73, 1'b0);
      send_frame(8'h73, 1'b0, 1'b1, 1'b0);

      // Watchdog abort also clears a pending break prefix
      send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
      push_err();
      send_partial(8'h73);
      wait_cyc(TOUT + 50);
      push_code(8'h73, 1'b0);
      send_frame(8'h73, 1'b0, 1'b1, 1'b0);

      // Reset mid-frame: reset values, no event afterwards
      push_code(8'h75, 1'b0);
      send_frame(8'h75, 1'b0, 1'b1, 1'b0);
      send_partial(8'h72);
      wait_cyc(2);
      rst = 1'b1;
      wait_cyc(3);
      check_reset_vals("midframe_rst");
      rst = 1'b0;
      wait_cyc(TOUT + 50);
      check_reset_vals("after_rst");
      push_code(8'h72, 1'b0);
      send_frame(8'h72, 1'b1, 1'b1, 1'b0);

      // Short clock glitches while idle and inside a frame
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(30);
      push_code(8'h73, 1'b0);
      send_frame(8'h73, 1'b0, 1'b1, 1'b1);

      wait_cyc(100);
      check_val("queue_drained", 8'(q.size()), 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/ps2_rx_teclado.md
# ps2_rx_teclado

PS/2 keyboard receiver that deserialises device-clocked frames into scan codes for the date/time adjust counters. It sits directly upstream of the day/month/year adjust counters: its `Cambio` byte and one-cycle `got_data` strobe drive their increment/decrement inputs. Break (key-release) sequences are swallowed, so a single keypress yields exactly one strobe.

## Interface
- `FILT`, default 8: consecutive identical synchronised samples required to change a filtered PS/2 line level.
- `TOUT`, default 50000: watchdog, in `clk` cycles, between falling edges inside a frame before the frame is aborted.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `ps2_clk` input 1: raw keyboard clock, asynchronous to `clk`.
- `ps2_data` input 1: raw keyboard data, asynchronous to `clk`.
- `Cambio` output 8: last accepted make code; holds its value between strobes.
- `got_data` output 1: one-cycle pulse when `Cambio` is updated.
- `extendido` output 1: the code in `Cambio` was prefixed by 0xE0; valid with `got_data`.
- `error` output 1: one-cycle pulse on a parity error, a stop-bit error or a watchdog abort.

## Operation
- Both PS/2 lines pass a 2-FF synchroniser, then a `FILT`-sample filter. A falling edge of the filtered clock is a one-cycle `caida` event.
- Frame format: start 0, 8 data bits LSB first, odd parity, stop 1. Sampling happens on `caida`.
- FSM states:
  - `IDLE`: a `caida` with data 0 moves to `DATOS` and clears the bit counter. A `caida` with data 1 is ignored.
  - `DATOS`: shift the data bit in at bit 7 of the shift register (shift right). After the 8th bit, move to `PARIDAD`.
  - `PARIDAD`: store the bit, move to `PARADA`.
  - `PARADA`: if the stop bit is 1 and `^{byte,parity}==1`, run byte handling. Otherwise pulse `error`. In both cases return to `IDLE`.
- Byte handling, with flags `f_break` and `f_ext`:
  - 0xE0 sets `f_ext`. No strobe.
  - 0xF0 sets `f_break`. No strobe.
  - Any other byte with `f_break`=1: clear both flags. No strobe.
  - Any other byte otherwise: set `Cambio`=byte, `extendido`=`f_ext`, pulse `got_data`, clear `f_ext`.
- Watchdog: a counter runs in every state except `IDLE` and clears on each `caida`. When it reaches `TOUT`-1: pulse `error`, return to `IDLE`, clear `f_break` and `f_ext`.
- A rejected frame (parity/stop error) leaves the flags unchanged.
- Reset values: `Cambio`=0x00, `got_data`=0, `extendido`=0, `error`=0, FSM=`IDLE`, flags=0. Both synchroniser stages and both filters reset to 1 (bus idle).
- Reset mid-frame discards the partial frame. No strobe follows reset.

## Timing
- Filter latency: a line change is seen on the filtered output `2+FILT` cycles after the pin changes, given a stable input.
- `caida` is asserted the cycle after the filtered clock goes 1→0.
- `Cambio`, `extendido`, `got_data` and `error` are registered. They update on the cycle after the `caida` that sampled the stop bit.
- `got_data` is high for exactly 1 cycle. The next strobe comes no sooner than one full frame later.
- Glitches shorter than `FILT` cycles on either line have no effect.
- The block drives nothing onto the PS/2 bus (receive only).

## Structure
- Shared package `ps2_codigos`: constants `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0, `TECLA_ARRIBA`=8'h75, `TECLA_ABAJO`=8'h72, `TECLA_SUBE`=8'h73, and the FSM state encodings.
- One sub-module, `ps2_filtro` (parameter `FILT`): synchroniser plus level filter. Instantiate it twice, once for `ps2_clk` and once for `ps2_data`.
- The top level holds the edge detect, FSM, shift register, watchdog and code handling.

## Test plan
- Frame 0x73 with parity 0 and stop 1 → one `got_data` pulse, `Cambio`=0x73, `extendido`=0, `error` stays 0.
- Sequence 0x72 / 0xF0 / 0x72 (parity 1, 1, 1) → exactly one `got_data` pulse, `Cambio`=0x72. The break pair produces no strobe.
- Sequence 0xE0 / 0x75 (parity 0, 0) → one pulse, `Cambio`=0x75, `extendido`=1. A following plain 0x73 gives `extendido`=0.
- Frame 0x73 with parity 1 → `error` pulse, no `got_data`, `Cambio` keeps its previous value. A following valid 0x72 is accepted normally.
- Stop after 4 data bits, idle `TOUT` cycles → `error` pulse, FSM back in `IDLE`. A following valid 0x73 is accepted. Repeat the same case with `rst` asserted mid-frame → outputs at reset values, no `error`, no strobe.
- 3-cycle low glitches on `ps2_clk` while idle and mid-frame (`FILT`=8) → no bit sampled, the frame decodes correctly.
